// File: rtl/arith_issue_queue_pkg.sv
// ============================================================================
//  Module      : arith_issue_queue_pkg
//  Description : Shared definitions for the arithmetic issue queue: default
//                sizing and the arithmetic uop encodings understood by the
//                arithmetic FU.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arith_issue_queue_pkg;

  // Default sizing of the arithmetic reservation station and its neighbours.
  localparam int XLEN_DEF          = 32;
  localparam int ROB_SIZE_DEF      = 256;
  localparam int PHYS_REG_SIZE_DEF = 256;
  localparam int UOP_SIZE_DEF      = 16;
  localparam int RS_DEPTH_DEF      = 8;

  // Arithmetic uop encodings, shared with the other FU queues.
  typedef enum logic [3:0] {
    UOP_ADD  = 4'd0,
    UOP_SUB  = 4'd1,
    UOP_SLT  = 4'd2,
    UOP_SLTU = 4'd3
  } arith_uop_e;

endpackage

`default_nettype wire

// File: rtl/arith_issue_queue_pick_oldest.sv
// ============================================================================
//  Module      : arith_issue_queue_pick_oldest
//  Description : Oldest-first picker. Slot 0 is the oldest entry, so the
//                lowest set bit of the ready vector wins.
//  Ports       : req    - per-slot ready vector
//                onehot - one-hot grant (all zero when nothing is ready)
//                idx    - binary index of the granted slot
//                any    - at least one slot is ready
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arith_issue_queue_pick_oldest
  import arith_issue_queue_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH_DEF
) (
  input  logic [DEPTH-1:0]         req,
  output logic [DEPTH-1:0]         onehot,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     any
);

  localparam int IW = $clog2(DEPTH);

  // Scan from the youngest slot down so the last hit is the oldest one.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (req[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IW'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/arith_issue_queue.sv
// ============================================================================
//  Module      : arith_issue_queue
//  Description : Reservation station for the single-cycle arithmetic FU.
//                Collapsing queue (slot 0 oldest) that captures operands from
//                the CDB and issues the oldest fully-ready uop each cycle.
//  Ports       : clk/rst        - clock, synchronous active-high reset
//                flush          - drop every entry (mispredict recovery)
//                alloc_*        - dispatch interface (valid/ready handshake)
//                cdb_*          - result broadcast used for operand wakeup
//                fu_ready       - FU can take an issue this cycle
//                issue_*        - registered issue to the FU
//                occupancy      - number of valid entries
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arith_issue_queue
  import arith_issue_queue_pkg::*;
#(
  parameter int XLEN          = XLEN_DEF,
  parameter int ROB_SIZE      = ROB_SIZE_DEF,
  parameter int PHYS_REG_SIZE = PHYS_REG_SIZE_DEF,
  parameter int UOP_SIZE      = UOP_SIZE_DEF,
  parameter int RS_DEPTH      = RS_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         alloc_valid,
  output logic                         alloc_ready,
  input  logic [$clog2(UOP_SIZE)-1:0]  alloc_uop,
  input  logic [$clog2(ROB_SIZE)-1:0]  alloc_rob,
  input  logic [$clog2(PHYS_REG_SIZE)-1:0] alloc_dest,
  input  logic [$clog2(PHYS_REG_SIZE)-1:0] alloc_src1_tag,
  input  logic                         alloc_src1_rdy,
  input  logic [XLEN-1:0]              alloc_src1_val,
  input  logic [$clog2(PHYS_REG_SIZE)-1:0] alloc_src2_tag,
  input  logic                         alloc_src2_rdy,
  input  logic [XLEN-1:0]              alloc_src2_val,
  input  logic [XLEN-1:0]              alloc_pc,
  input  logic                         cdb_valid,
  input  logic [$clog2(PHYS_REG_SIZE)-1:0] cdb_tag,
  input  logic [XLEN-1:0]              cdb_data,
  input  logic                         fu_ready,
  output logic                         issue_valid,
  output logic [$clog2(UOP_SIZE)-1:0]  issue_uop,
  output logic [$clog2(ROB_SIZE)-1:0]  issue_rob,
  output logic [$clog2(PHYS_REG_SIZE)-1:0] issue_dest,
  output logic [XLEN-1:0]              issue_rs1,
  output logic [XLEN-1:0]              issue_rs2,
  output logic [XLEN-1:0]              issue_pc,
  output logic [$clog2(RS_DEPTH):0]    occupancy
);

  localparam int TW = $clog2(PHYS_REG_SIZE);
  localparam int RW = $clog2(ROB_SIZE);
  localparam int UW = $clog2(UOP_SIZE);
  localparam int IW = $clog2(RS_DEPTH);
  localparam int CW = IW + 1;

  typedef struct packed {
    logic [UW-1:0]   uop;
    logic [RW-1:0]   rob;
    logic [TW-1:0]   dest;
    logic [TW-1:0]   s1_tag;
    logic            s1_rdy;
    logic [XLEN-1:0] s1_val;
    logic [TW-1:0]   s2_tag;
    logic            s2_rdy;
    logic [XLEN-1:0] s2_val;
    logic [XLEN-1:0] pc;
  } entry_t;

  typedef struct packed {
    logic [UW-1:0]   uop;
    logic [RW-1:0]   rob;
    logic [TW-1:0]   dest;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] pc;
  } issue_t;

  // Capture a broadcast result into any still-waiting source of an entry.
  function automatic entry_t wake(input entry_t          e,
                                  input logic            cv,
                                  input logic [TW-1:0]   ct,
                                  input logic [XLEN-1:0] cd);
    entry_t r;
    r = e;
    if (cv && !e.s1_rdy && (e.s1_tag == ct)) begin
      r.s1_rdy = 1'b1;
      r.s1_val = cd;
    end
    if (cv && !e.s2_rdy && (e.s2_tag == ct)) begin
      r.s2_rdy = 1'b1;
      r.s2_val = cd;
    end
    return r;
  endfunction

  entry_t              ent_q  [RS_DEPTH];
  entry_t              ent_d  [RS_DEPTH];
  entry_t              ent_up [RS_DEPTH];
  entry_t              alloc_ent;
  logic [CW-1:0]       count_q, count_d;
  issue_t              issue_q, issue_d;
  logic                issue_valid_q, issue_valid_d;
  logic [RS_DEPTH-1:0] rdy_vec;
  logic [RS_DEPTH-1:0] pick_onehot;
  logic [IW-1:0]       pick_idx;
  logic                pick_any;
  logic                issue_fire;
  logic                alloc_fire;
  logic [IW-1:0]       alloc_slot;

  // Readiness comes only from registered state, so a wakeup at one edge
  // makes the entry selectable in the following cycle.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      rdy_vec[i] = (CW'(i) < count_q) && ent_q[i].s1_rdy && ent_q[i].s2_rdy;
    end
  end

  arith_issue_queue_pick_oldest #(
    .DEPTH (RS_DEPTH)
  ) u_pick (
    .req    (rdy_vec),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // No credit is given for a same-cycle issue: a full queue stays closed.
  assign alloc_ready = (count_q < CW'(RS_DEPTH));
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign issue_fire  = fu_ready && pick_any;

  // Neighbour-above view for the collapse; the top slot has no neighbour
  // and becomes invalid whenever a shift happens.
  for (genvar g = 0; g < RS_DEPTH; g++) begin : g_shift
    if (g < RS_DEPTH - 1) begin : g_mid
      assign ent_up[g] = ent_q[g+1];
    end else begin : g_top
      assign ent_up[g] = ent_q[g];
    end
  end

  always_comb begin
    alloc_ent.uop    = alloc_uop;
    alloc_ent.rob    = alloc_rob;
    alloc_ent.dest   = alloc_dest;
    alloc_ent.s1_tag = alloc_src1_tag;
    alloc_ent.s1_rdy = alloc_src1_rdy;
    alloc_ent.s1_val = alloc_src1_val;
    alloc_ent.s2_tag = alloc_src2_tag;
    alloc_ent.s2_rdy = alloc_src2_rdy;
    alloc_ent.s2_val = alloc_src2_val;
    alloc_ent.pc     = alloc_pc;
  end

  // Entry next-state: collapse over the issued slot, then wake the shifted
  // data; a new uop lands just above the surviving entries and is woken too
  // (dispatch/CDB bypass).
  always_comb begin
    alloc_slot = IW'(count_q - CW'(issue_fire));
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (issue_fire && (IW'(i) >= pick_idx)) begin
        ent_d[i] = wake(ent_up[i], cdb_valid, cdb_tag, cdb_data);
      end else begin
        ent_d[i] = wake(ent_q[i], cdb_valid, cdb_tag, cdb_data);
      end
    end
    if (alloc_fire && !flush) begin
      ent_d[alloc_slot] = wake(alloc_ent, cdb_valid, cdb_tag, cdb_data);
    end
  end

  always_comb begin
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CW'(alloc_fire) - CW'(issue_fire);
    end
  end

  // Issue registers hold their last value when nothing issues.
  always_comb begin
    issue_d       = issue_q;
    issue_valid_d = 1'b0;
    if (issue_fire && !flush) begin
      issue_valid_d = 1'b1;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (pick_onehot[i]) begin
          issue_d.uop  = ent_q[i].uop;
          issue_d.rob  = ent_q[i].rob;
          issue_d.dest = ent_q[i].dest;
          issue_d.rs1  = ent_q[i].s1_val;
          issue_d.rs2  = ent_q[i].s2_val;
          issue_d.pc   = ent_q[i].pc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_q       <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      count_q       <= count_d;
      issue_valid_q <= issue_valid_d;
      issue_q       <= issue_d;
      for (int i = 0; i < RS_DEPTH; i++) begin
        ent_q[i] <= ent_d[i];
      end
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_uop   = issue_q.uop;
  assign issue_rob   = issue_q.rob;
  assign issue_dest  = issue_q.dest;
  assign issue_rs1   = issue_q.rs1;
  assign issue_rs2   = issue_q.rs2;
  assign issue_pc    = issue_q.pc;
  assign occupancy   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_arith_issue_queue.sv
// ============================================================================
//  Module      : tb_arith_issue_queue
//  Description : Self-checking bench for arith_issue_queue. Expected issues
//                are queued as stimulus is driven and compared in order as
//                the queue issues them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arith_issue_queue;
  import arith_issue_queue_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [3:0]  alloc_uop;
  logic [7:0]  alloc_rob;
  logic [7:0]  alloc_dest;
  logic [7:0]  alloc_src1_tag;
  logic        alloc_src1_rdy;
  logic [31:0] alloc_src1_val;
  logic [7:0]  alloc_src2_tag;
  logic        alloc_src2_rdy;
  logic [31:0] alloc_src2_val;
  logic [31:0] alloc_pc;
  logic        cdb_valid;
  logic [7:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        fu_ready;
  logic        issue_valid;
  logic [3:0]  issue_uop;
  logic [7:0]  issue_rob;
  logic [7:0]  issue_dest;
  logic [31:0] issue_rs1;
  logic [31:0] issue_rs2;
  logic [31:0] issue_pc;
  logic [3:0]  occupancy;

  typedef struct {
    logic [3:0]  uop;
    logic [7:0]  rob;
    logic [7:0]  dest;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  arith_issue_queue dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_uop      (alloc_uop),
    .alloc_rob      (alloc_rob),
    .alloc_dest     (alloc_dest),
    .alloc_src1_tag (alloc_src1_tag),
    .alloc_src1_rdy (alloc_src1_rdy),
    .alloc_src1_val (alloc_src1_val),
    .alloc_src2_tag (alloc_src2_tag),
    .alloc_src2_rdy (alloc_src2_rdy),
    .alloc_src2_val (alloc_src2_val),
    .alloc_pc       (alloc_pc),
    .cdb_valid      (cdb_valid),
    .cdb_tag        (cdb_tag),
    .cdb_data       (cdb_data),
    .fu_ready       (fu_ready),
    .issue_valid    (issue_valid),
    .issue_uop      (issue_uop),
    .issue_rob      (issue_rob),
    .issue_dest     (issue_dest),
    .issue_rs1      (issue_rs1),
    .issue_rs2      (issue_rs2),
    .issue_pc       (issue_pc),
    .occupancy      (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Scoreboard: every issue must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && issue_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_issue: got rob=%0d rs1=%h, required no issue", issue_rob, issue_rs1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({issue_uop, issue_rob, issue_dest, issue_rs1, issue_rs2, issue_pc} !==
            {e.uop, e.rob, e.dest, e.rs1, e.rs2, e.pc}) begin
          $display("FAIL issue_fields: got uop=%0d rob=%0d dest=%0d rs1=%h rs2=%h pc=%h, required uop=%0d rob=%0d dest=%0d rs1=%h rs2=%h pc=%h",
                   issue_uop, issue_rob, issue_dest, issue_rs1, issue_rs2, issue_pc,
                   e.uop, e.rob, e.dest, e.rs1, e.rs2, e.pc);
        end else begin
          n_pass++;
        end
      end
    end
  end

  task automatic push_exp(input logic [3:0] uop, input logic [7:0] rob, input logic [7:0] dest,
                          input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] pc);
    exp_t e;
    e.uop = uop; e.rob = rob; e.dest = dest; e.rs1 = rs1; e.rs2 = rs2; e.pc = pc;
    exp_q.push_back(e);
  endtask

  // One-cycle dispatch; the handshake fires at the next rising edge.
  task automatic do_alloc(input logic [3:0] uop, input logic [7:0] rob, input logic [7:0] dest,
                          input logic [7:0] t1, input logic r1, input logic [31:0] v1,
                          input logic [7:0] t2, input logic r2, input logic [31:0] v2,
                          input logic [31:0] pc);
    alloc_valid = 1'b1; alloc_uop = uop; alloc_rob = rob; alloc_dest = dest;
    alloc_src1_tag = t1; alloc_src1_rdy = r1; alloc_src1_val = v1;
    alloc_src2_tag = t2; alloc_src2_rdy = r2; alloc_src2_val = v2;
    alloc_pc = pc;
    @(posedge clk); #1;
    alloc_valid = 1'b0;
  endtask

  task automatic cdb_pulse(input logic [7:0] tag, input logic [31:0] data);
    cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
    @(posedge clk); #1;
    cdb_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; fu_ready = 1'b0;
    alloc_uop = '0; alloc_rob = '0; alloc_dest = '0; alloc_pc = '0;
    alloc_src1_tag = '0; alloc_src1_rdy = 1'b0; alloc_src1_val = '0;
    alloc_src2_tag = '0; alloc_src2_rdy = 1'b0; alloc_src2_val = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({occupancy, alloc_ready, issue_valid} !== {4'd0, 1'b1, 1'b0}) begin
      $display("FAIL reset_state: got occ=%0d rdy=%b iv=%b, required occ=0 rdy=1 iv=0", occupancy, alloc_ready, issue_valid);
    end else n_pass++;
    n_checks++;
    if ({issue_uop, issue_rob, issue_dest, issue_rs1, issue_rs2, issue_pc} !== '0) begin
      $display("FAIL reset_issue_fields: got rob=%0d rs1=%h pc=%h, required all zero", issue_rob, issue_rs1, issue_pc);
    end else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic_issue();
    fu_ready = 1'b1;
    push_exp(UOP_ADD, 8'd5, 8'd10, 32'd3, 32'd4, 32'h100);
    do_alloc(UOP_ADD, 8'd5, 8'd10, 8'd1, 1'b1, 32'd3, 8'd2, 1'b1, 32'd4, 32'h100);
    @(negedge clk);
    n_checks++;
    if ({issue_valid, occupancy} !== {1'b0, 4'd1}) begin
      $display("FAIL basic_first_cycle: got iv=%b occ=%0d, required iv=0 occ=1", issue_valid, occupancy);
    end else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({issue_valid, occupancy} !== {1'b1, 4'd0}) begin
      $display("FAIL basic_issue_latency: got iv=%b occ=%0d, required iv=1 occ=0", issue_valid, occupancy);
    end else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({issue_valid, issue_rob, issue_rs1} !== {1'b0, 8'd5, 32'd3}) begin
      $display("FAIL basic_hold: got iv=%b rob=%0d rs1=%h, required iv=0 rob=5 rs1=3", issue_valid, issue_rob, issue_rs1);
    end else n_pass++;
  endtask

  task automatic test_wakeup();
    fu_ready = 1'b1;
    push_exp(UOP_SUB, 8'd6, 8'd11, 32'hAB, 32'd7, 32'h104);
    do_alloc(UOP_SUB, 8'd6, 8'd11, 8'd17, 1'b0, 32'hDEAD, 8'd3, 1'b1, 32'd7, 32'h104);
    repeat (2) @(negedge clk);
    n_checks++;
    if ({issue_valid, occupancy} !== {1'b0, 4'd1}) begin
      $display("FAIL wakeup_waiting: got iv=%b occ=%0d, required iv=0 occ=1", issue_valid, occupancy);
    end else n_pass++;
    cdb_pulse(8'd17, 32'hAB);
    @(negedge clk);
    n_checks++;
    if (issue_valid !== 1'b0) begin
      $display("FAIL wakeup_not_same_cycle: got iv=%b, required iv=0", issue_valid);
    end else n_pass++;
    @(negedge clk);
    n_checks++;
    if (issue_valid !== 1'b1) begin
      $display("FAIL wakeup_issue: got iv=%b, required iv=1", issue_valid);
    end else n_pass++;
  endtask

  task automatic test_bypass();
    fu_ready = 1'b1;
    push_exp(UOP_SLT, 8'd7, 8'd12, 32'd1, 32'h55, 32'h108);
    cdb_valid = 1'b1; cdb_tag = 8'd9; cdb_data = 32'h55;
    do_alloc(UOP_SLT, 8'd7, 8'd12, 8'd4, 1'b1, 32'd1, 8'd9, 1'b0, 32'd0, 32'h108);
    cdb_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (issue_valid !== 1'b1) begin
      $display("FAIL bypass_issue: got iv=%b, required iv=1", issue_valid);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    fu_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_exp(UOP_SLTU, 8'(30 + i), 8'(70 + i), 32'(100 + i), 32'(200 + i), 32'(32'h200 + 4 * i));
      do_alloc(UOP_SLTU, 8'(30 + i), 8'(70 + i), 8'd1, 1'b1, 32'(100 + i), 8'd2, 1'b1, 32'(200 + i),
               32'(32'h200 + 4 * i));
    end
    @(negedge clk);
    n_checks++;
    if (occupancy !== 4'd1) begin
      $display("FAIL b2b_occupancy: got occ=%0d, required occ=1", occupancy);
    end else n_pass++;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    // Stalled FU: ready entries must wait.
    fu_ready = 1'b0;
    push_exp(UOP_ADD, 8'd40, 8'd80, 32'h11, 32'h22, 32'h300);
    push_exp(UOP_SUB, 8'd41, 8'd81, 32'h33, 32'h44, 32'h304);
    do_alloc(UOP_ADD, 8'd40, 8'd80, 8'd1, 1'b1, 32'h11, 8'd2, 1'b1, 32'h22, 32'h300);
    do_alloc(UOP_SUB, 8'd41, 8'd81, 8'd1, 1'b1, 32'h33, 8'd2, 1'b1, 32'h44, 32'h304);
    repeat (3) @(negedge clk);
    n_checks++;
    if ({issue_valid, occupancy} !== {1'b0, 4'd2}) begin
      $display("FAIL stall_no_issue: got iv=%b occ=%0d, required iv=0 occ=2", issue_valid, occupancy);
    end else n_pass++;
    fu_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL b2b_drain: got %0d outstanding, required 0", exp_q.size());
    end else n_pass++;
  endtask

  task automatic test_fill_and_order();
    fu_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      // Slots 2 and 6 share a source tag so one broadcast wakes both.
      do_alloc(UOP_ADD, 8'(20 + i), 8'(90 + i), (i == 2 || i == 6) ? 8'd50 : 8'(40 + i), 1'b0, 32'd0,
               8'd3, 1'b1, 32'(i), 32'(32'h400 + 4 * i));
    end
    @(negedge clk);
    n_checks++;
    if ({occupancy, alloc_ready} !== {4'd8, 1'b0}) begin
      $display("FAIL full_state: got occ=%0d rdy=%b, required occ=8 rdy=0", occupancy, alloc_ready);
    end else n_pass++;
    push_exp(UOP_ADD, 8'd22, 8'd92, 32'h77, 32'd2, 32'h408);
    push_exp(UOP_ADD, 8'd26, 8'd96, 32'h77, 32'd6, 32'h418);
    cdb_pulse(8'd50, 32'h77);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({issue_valid, occupancy, alloc_ready} !== {1'b1, 4'd7, 1'b1}) begin
      $display("FAIL after_first_issue: got iv=%b occ=%0d rdy=%b, required iv=1 occ=7 rdy=1", issue_valid, occupancy, alloc_ready);
    end else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({issue_valid, occupancy} !== {1'b1, 4'd6}) begin
      $display("FAIL after_second_issue: got iv=%b occ=%0d, required iv=1 occ=6", issue_valid, occupancy);
    end else n_pass++;
  endtask

  task automatic test_stall_and_flush();
    logic [7:0] tags [6];
    tags = '{8'd40, 8'd41, 8'd43, 8'd44, 8'd45, 8'd47};
    fu_ready = 1'b0;
    foreach (tags[i]) cdb_pulse(tags[i], 32'hC0DE0000 + 32'(i));
    repeat (3) @(negedge clk);
    n_checks++;
    if ({issue_valid, occupancy} !== {1'b0, 4'd6}) begin
      $display("FAIL fu_stall: got iv=%b occ=%0d, required iv=0 occ=6", issue_valid, occupancy);
    end else n_pass++;
    // Flush beats a concurrent issue, allocation and broadcast.
    fu_ready = 1'b1; flush = 1'b1; cdb_valid = 1'b1; cdb_tag = 8'd1; cdb_data = 32'h1;
    do_alloc(UOP_ADD, 8'd99, 8'd99, 8'd1, 1'b1, 32'h9, 8'd2, 1'b1, 32'h9, 32'h900);
    flush = 1'b0; cdb_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({occupancy, issue_valid, alloc_ready} !== {4'd0, 1'b0, 1'b1}) begin
      $display("FAIL flush_state: got occ=%0d iv=%b rdy=%b, required occ=0 iv=0 rdy=1", occupancy, issue_valid, alloc_ready);
    end else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    fu_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_alloc(UOP_SUB, 8'(60 + i), 8'(60 + i), 8'(60 + i), 1'b0, 32'd0, 8'd3, 1'b1, 32'd5, 32'h500);
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({occupancy, alloc_ready, issue_valid, issue_rs1, issue_pc} !== {4'd0, 1'b1, 1'b0, 32'd0, 32'd0}) begin
      $display("FAIL mid_reset: got occ=%0d rdy=%b iv=%b rs1=%h pc=%h, required occ=0 rdy=1 iv=0 rs1=0 pc=0",
               occupancy, alloc_ready, issue_valid, issue_rs1, issue_pc);
    end else n_pass++;
    cdb_pulse(8'd60, 32'hBAD);
    push_exp(UOP_ADD, 8'd0, 8'd0, 32'hF0, 32'h0F, 32'h600);
    do_alloc(UOP_ADD, 8'd0, 8'd0, 8'd0, 1'b1, 32'hF0, 8'd0, 1'b1, 32'h0F, 32'h600);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL post_reset_drain: got %0d outstanding, required 0", exp_q.size());
    end else n_pass++;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic_issue();
    test_wakeup();
    test_bypass();
    test_back_to_back();
    test_fill_and_order();
    test_stall_and_flush();
    test_mid_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL final_scoreboard: got %0d outstanding, required 0", exp_q.size());
    end else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
